level_monitor: RTL and testbench

Per-level rules engine sitting directly upstream of the game FSM. It consumes collection and collision events from the scroll and obstacle arrays, and tracks three things: scrolls remaining, the level countdown timer, and player lives. It emits the single-cycle `level_passed` and `lose` strobes that the FSM uses to advance the level/world or end the game. It also exports its counters for on-screen display.

---
 rtl/level_monitor.sv | 132 +++++++++++++
 tb/tb_level_monitor.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/level_monitor.sv
// level_monitor: per-level rules engine tracking scrolls, countdown timer and lives.
// Emits one-cycle level_passed / lose strobes to the game FSM.
module level_monitor #(
    parameter int CLK_HZ            = 100000000,
    parameter int SCROLLS_PER_LEVEL = 24,
    parameter int LEVEL_TIME        = 60,
    parameter int LIVES_INIT        = 3,
    parameter int HIT_GUARD         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_start,
    input  logic       scroll_hit,
    input  logic       wall_hit,
    output logic       level_passed,
    output logic       lose,
    output logic [4:0] scrolls_left,
    output logic [7:0] time_left,
    output logic [1:0] lives,
    output logic       running
);

    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int GW = (HIT_GUARD > 0) ? $clog2(HIT_GUARD + 1) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
    localparam logic [GW-1:0] GUARD_LD = GW'(HIT_GUARD);
    localparam logic [4:0] SCR_LD = 5'(SCROLLS_PER_LEVEL);
    localparam logic [7:0] TIME_LD = 8'(LEVEL_TIME);
    localparam logic [1:0] LIVES_LD = 2'(LIVES_INIT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PASSED,
        S_LOST
    } state_t;

    state_t r_state, w_state_nx;

    logic [PW-1:0] r_pre, w_pre_nx;
    logic [GW-1:0] r_guard, w_guard_nx;
    logic [4:0] r_scrolls, w_scrolls_nx;
    logic [7:0] r_time, w_time_nx;
    logic [1:0] r_lives, w_lives_nx;
    logic r_pass, w_pass_nx;
    logic r_lose, w_lose_nx;
    logic r_run, w_run_nx;
    logic w_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_guard   <= '0;
            r_scrolls <= '0;
            r_time    <= '0;
            r_lives   <= LIVES_LD;
            r_pass    <= 1'b0;
            r_lose    <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_pre     <= w_pre_nx;
            r_guard   <= w_guard_nx;
            r_scrolls <= w_scrolls_nx;
            r_time    <= w_time_nx;
            r_lives   <= w_lives_nx;
            r_pass    <= w_pass_nx;
            r_lose    <= w_lose_nx;
            r_run     <= w_run_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_pre_nx     = r_pre;
        w_guard_nx   = r_guard;
        w_scrolls_nx = r_scrolls;
        w_time_nx    = r_time;
        w_lives_nx   = r_lives;
        w_pass_nx    = 1'b0;
        w_lose_nx    = 1'b0;
        w_tick       = 1'b0;

        if (level_start) begin
            // Reload wins over any coincident event.
            w_state_nx   = S_RUN;
            w_pre_nx     = '0;
            w_guard_nx   = '0;
            w_scrolls_nx = SCR_LD;
            w_time_nx    = TIME_LD;
            if (r_lives == 2'd0) begin
                w_lives_nx = LIVES_LD;
            end
        end else if (r_state == S_RUN) begin
            w_tick   = (r_pre == PRE_MAX);
            w_pre_nx = w_tick ? '0 : r_pre + 1'b1;
            if (w_tick && r_time != 8'd0) begin
                w_time_nx = r_time - 8'd1;
            end
            if (w_tick && r_guard != '0) begin
                w_guard_nx = r_guard - 1'b1;
            end
            if (scroll_hit && r_scrolls != 5'd0) begin
                w_scrolls_nx = r_scrolls - 5'd1;
            end
            // Guard is judged on its value before this cycle's tick.
            if (wall_hit && r_guard == '0 && r_lives != 2'd0) begin
                w_lives_nx = r_lives - 2'd1;
                w_guard_nx = GUARD_LD;
            end
            if (w_scrolls_nx == 5'd0) begin
                w_state_nx = S_PASSED;
                w_pass_nx  = 1'b1;
            end else if (w_lives_nx == 2'd0 || w_time_nx == 8'd0) begin
                w_state_nx = S_LOST;
                w_lose_nx  = 1'b1;
            end
        end

        w_run_nx = (w_state_nx == S_RUN);
    end

    assign level_passed = r_pass;
    assign lose         = r_lose;
    assign scrolls_left = r_scrolls;
    assign time_left    = r_time;
    assign lives        = r_lives;
    assign running      = r_run;

endmodule

// File: tb/tb_level_monitor.sv
// Scoreboard bench for level_monitor: a seconds-based reference model
// predicts each cycle's outputs; a monitor pops and compares them.
module tb_level_monitor;

    localparam int CLK = 10;
    localparam int SP  = 3;
    localparam int LT  = 5;
    localparam int LI  = 3;
    localparam int HG  = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       level_start = 1'b0;
    logic       scroll_hit = 1'b0;
    logic       wall_hit = 1'b0;
    logic       level_passed;
    logic       lose;
    logic [4:0] scrolls_left;
    logic [7:0] time_left;
    logic [1:0] lives;
    logic       running;

    level_monitor #(
        .CLK_HZ(CLK),
        .SCROLLS_PER_LEVEL(SP),
        .LEVEL_TIME(LT),
        .LIVES_INIT(LI),
        .HIT_GUARD(HG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .level_start(level_start),
        .scroll_hit(scroll_hit),
        .wall_hit(wall_hit),
        .level_passed(level_passed),
        .lose(lose),
        .scrolls_left(scrolls_left),
        .time_left(time_left),
        .lives(lives),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int l;
        int run;
        int sc;
        int tm;
        int lv;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int m_pass_cnt = 0;
    int m_lose_cnt = 0;
    int d_pass_cnt = 0;
    int d_lose_cnt = 0;

    // Model: 0 idle, 1 run, 2 passed, 3 lost
    int m_st = 0;
    int m_n = 0;
    int m_until = 0;
    int m_sc = 0;
    int m_tm = 0;
    int m_lv = LI;

    task automatic check(string name, int got, int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL cyc=%0d %s got=%0d exp=%0d", cyc, name, got, exp);
        end
    endtask

    task automatic model_step(input bit ls, input bit sh,
                              input bit wh, input bit r);
        exp_t e;
        int sb;
        int sa;
        e.p = 0;
        e.l = 0;
        if (r) begin
            m_st = 0; m_sc = 0; m_tm = 0; m_lv = LI;
            m_n = 0; m_until = 0;
        end else if (ls) begin
            m_st = 1; m_sc = SP; m_tm = LT;
            if (m_lv == 0) m_lv = LI;
            m_n = 0; m_until = 0;
        end else if (m_st == 1) begin
            sb = m_n / CLK;
            sa = (m_n + 1) / CLK;
            m_n++;
            m_tm = (sa >= LT) ? 0 : LT - sa;
            if (sh && m_sc > 0) m_sc--;
            if (wh && sb >= m_until && m_lv > 0) begin
                m_lv--;
                m_until = sa + HG;
            end
            if (m_sc == 0) begin
                m_st = 2; e.p = 1;
            end else if (m_lv == 0 || m_tm == 0) begin
                m_st = 3; e.l = 1;
            end
        end
        e.run = (m_st == 1);
        e.sc = m_sc;
        e.tm = m_tm;
        e.lv = m_lv;
        m_pass_cnt += e.p;
        m_lose_cnt += e.l;
        q.push_back(e);
    endtask

    task automatic step(input bit ls, input bit sh,
                        input bit wh, input bit r);
        @(negedge clk);
        level_start = ls;
        scroll_hit = sh;
        wall_hit = wh;
        rst = r;
        model_step(ls, sh, wh, r);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                cyc++;
                d_pass_cnt += int'(level_passed);
                d_lose_cnt += int'(lose);
                check("level_passed", int'(level_passed), e.p);
                check("lose", int'(lose), e.l);
                check("running", int'(running), e.run);
                check("scrolls_left", int'(scrolls_left), e.sc);
                check("time_left", int'(time_left), e.tm);
                check("lives", int'(lives), e.lv);
            end
        end
    end

    initial begin
        bit wh;
        int waited;
        // reset and idle events ignored
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        // start and first timer tick
        step(1, 0, 0, 0);
        idle(12);
        // three spaced scrolls then an ignored fourth
        step(0, 1, 0, 0); idle(1);
        step(0, 1, 0, 0); idle(1);
        step(0, 1, 0, 0); idle(1);
        step(0, 1, 0, 0); idle(3);
        // wall held from start
        step(1, 0, 1, 0);
        for (int i = 0; i < 35; i++) step(0, 0, 1, 0);
        // timeout with no events
        step(1, 0, 0, 0);
        idle(55);
        // last scroll coincides with final timer wrap
        step(1, 0, 0, 0);
        for (int i = 1; i <= 53; i++)
            step(0, (i == 10 || i == 20 || i == 50), 0, 0);
        // mid-run restart with lives carried
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        idle(4);
        // reset mid-run
        step(0, 0, 0, 1);
        idle(3);
        // random traffic
        wh = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) wh = ~wh;
            step(($urandom_range(0, 149) == 0),
                 ($urandom_range(0, 7) == 0), wh,
                 ($urandom_range(0, 999) == 0));
            if ($urandom_range(0, 59) == 0) step(1, 0, wh, 0);
        end
        idle(2);
        waited = 0;
        while (q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        check("queue_drained", q.size(), 0);
        check("pass_pulses", d_pass_cnt, m_pass_cnt);
        check("lose_pulses", d_lose_cnt, m_lose_cnt);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
